// File: rtl/ivector_pkg.sv
// ivector_pkg
// Shared constants and helpers for the ivector_queue relay.
//   MODE_BACKPRESSURE : a full buffer lowers say__RDY until a slot frees.
//   MODE_DROP_OLDEST  : a full buffer accepts new requests and discards the head.
//   clog2             : elaboration-time ceiling log2, used for pointer widths.
// The {meth, v} entry struct depends on module parameters, so it is declared
// inside the modules that use it rather than here.
package ivector_pkg;

   localparam int MODE_BACKPRESSURE = 0;
   localparam int MODE_DROP_OLDEST  = 1;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ivector_queue_ram.sv
// ivector_queue_ram
// Entry storage for ivector_queue: DEPTH words of WIDTH bits, one write port,
// one asynchronous read port. Contents are not reset.
// Ports:
//   CLK   - clock, write happens on the rising edge
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data, combinational from raddr
module ivector_queue_ram
   import ivector_pkg::*;
#(
   parameter  int WIDTH = 384,
   parameter  int DEPTH = 4,
   localparam int AW    = clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // The head must be visible in the same cycle it is delivered.
   assign rdata = mem[raddr];

endmodule

// File: rtl/ivector_queue.sv
// ivector_queue
// Request/indication relay: every accepted say(meth, v) is re-emitted, in
// order, as ind_heard(meth, v) from a DEPTH-entry circular buffer.
// Ports:
//   CLK, nRST             - clock and asynchronous active-low reset
//   say__ENA/meth/v/RDY   - request port
//   ind_heard__ENA/...    - indication port, head entry shown combinationally
//   ind_heard__RDY        - indication consumer ready
//   flush                 - clears buffered entries at the next edge
//   occupancy             - entries currently held
//   drop_count            - entries discarded in drop-oldest mode (saturating)
//   heard_seq             - number of delivered indications, wrapping
module ivector_queue
   import ivector_pkg::*;
#(
   parameter  int META_W = 192,
   parameter  int DATA_W = 192,
   parameter  int DEPTH  = 4,
   parameter  int MODE   = MODE_BACKPRESSURE,
   parameter  int SEQ_W  = 11,
   parameter  int CNT_W  = 16,
   localparam int AW     = clog2(DEPTH),
   localparam int OW     = clog2(DEPTH) + 1
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              say__ENA,
   input  logic [META_W-1:0] say_meth,
   input  logic [DATA_W-1:0] say_v,
   output logic              say__RDY,
   output logic              ind_heard__ENA,
   output logic [META_W-1:0] ind_heard_heard_meth,
   output logic [DATA_W-1:0] ind_heard_heard_v,
   input  logic              ind_heard__RDY,
   input  logic              flush,
   output logic [OW-1:0]     occupancy,
   output logic [CNT_W-1:0]  drop_count,
   output logic [SEQ_W-1:0]  heard_seq
);

   typedef struct packed {
      logic [META_W-1:0] meth;
      logic [DATA_W-1:0] v;
   } entry_t;

   logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
   logic [OW-1:0]    occ_reg, occ_next;
   logic [SEQ_W-1:0] seq_reg, seq_next;
   logic [CNT_W-1:0] drop_reg, drop_next;

   logic   full, empty, enq, deq, drop;
   entry_t wr_entry, head;

   assign full  = (occ_reg == OW'(DEPTH));
   assign empty = (occ_reg == '0);

   // Depends only on registered occupancy, never on the indication ready.
   assign say__RDY = (MODE == MODE_DROP_OLDEST) ? 1'b1 : !full;

   assign enq = say__ENA & say__RDY & !flush;
   assign deq = !empty & ind_heard__RDY & !flush;

   // Overwrite-the-head case: when full, wr_ptr equals rd_ptr, so writing the
   // new entry and advancing both pointers discards exactly the oldest entry.
   assign drop = enq & full & !deq;

   assign ind_heard__ENA = deq;

   assign wr_entry.meth = say_meth;
   assign wr_entry.v    = say_v;

   ivector_queue_ram #(
      .WIDTH (META_W + DATA_W),
      .DEPTH (DEPTH)
   ) u_ram (
      .CLK   (CLK),
      .we    (enq),
      .waddr (wr_ptr_reg),
      .wdata (wr_entry),
      .raddr (rd_ptr_reg),
      .rdata (head)
   );

   assign ind_heard_heard_meth = empty ? '0 : head.meth;
   assign ind_heard_heard_v    = empty ? '0 : head.v;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      occ_next    = occ_reg;
      seq_next    = seq_reg;
      drop_next   = drop_reg;
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         occ_next    = '0;
      end else begin
         if (enq) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
         end
         if (deq || drop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
         end
         if (enq && !deq && !drop) begin
            occ_next = occ_reg + 1'b1;
         end else if (deq && !enq) begin
            occ_next = occ_reg - 1'b1;
         end
         if (deq) begin
            seq_next = seq_reg + 1'b1;
         end
         if (drop && (drop_reg != '1)) begin
            drop_next = drop_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         occ_reg    <= '0;
         seq_reg    <= '0;
         drop_reg   <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         occ_reg    <= occ_next;
         seq_reg    <= seq_next;
         drop_reg   <= drop_next;
      end
   end

   assign occupancy  = occ_reg;
   assign drop_count = drop_reg;
   assign heard_seq  = seq_reg;

endmodule

// File: tb/tb_ivector_queue.sv
// tb_ivector_queue
// Drives one backpressure instance and one drop-oldest instance with the same
// stimulus and compares every output, every cycle, against a queue model.
module tb_ivector_queue;

   localparam int MW    = 16;
   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int SEQ_W = 11;
   localparam int CNT_W = 16;
   localparam int OW    = 3;

   logic          CLK = 1'b0;
   logic          nRST = 1'b0;
   logic          ena = 1'b0;
   logic          rdy = 1'b0;
   logic          fl  = 1'b0;
   logic [MW-1:0] meth = '0;
   logic [DW-1:0] v    = '0;

   logic             srdy [2];
   logic             hena [2];
   logic [MW-1:0]    hmeth [2];
   logic [DW-1:0]    hv [2];
   logic [OW-1:0]    occ [2];
   logic [CNT_W-1:0] dcnt [2];
   logic [SEQ_W-1:0] hseq [2];

   always #5 CLK = ~CLK;

   ivector_queue #(.META_W(MW), .DATA_W(DW), .DEPTH(DEPTH), .MODE(0),
                   .SEQ_W(SEQ_W), .CNT_W(CNT_W)) dut0 (
      .CLK(CLK), .nRST(nRST), .say__ENA(ena), .say_meth(meth), .say_v(v),
      .say__RDY(srdy[0]), .ind_heard__ENA(hena[0]),
      .ind_heard_heard_meth(hmeth[0]), .ind_heard_heard_v(hv[0]),
      .ind_heard__RDY(rdy), .flush(fl), .occupancy(occ[0]),
      .drop_count(dcnt[0]), .heard_seq(hseq[0]));

   ivector_queue #(.META_W(MW), .DATA_W(DW), .DEPTH(DEPTH), .MODE(1),
                   .SEQ_W(SEQ_W), .CNT_W(CNT_W)) dut1 (
      .CLK(CLK), .nRST(nRST), .say__ENA(ena), .say_meth(meth), .say_v(v),
      .say__RDY(srdy[1]), .ind_heard__ENA(hena[1]),
      .ind_heard_heard_meth(hmeth[1]), .ind_heard_heard_v(hv[1]),
      .ind_heard__RDY(rdy), .flush(fl), .occupancy(occ[1]),
      .drop_count(dcnt[1]), .heard_seq(hseq[1]));

   // Reference model: a plain queue of {meth, v} per instance.
   logic [31:0]      q0 [$];
   logic [31:0]      q1 [$];
   logic [SEQ_W-1:0] mseq [2];
   logic [CNT_W-1:0] mdrop [2];
   int               deliv [2];

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++) begin
         mseq[k]  = '0;
         mdrop[k] = '0;
         deliv[k] = 0;
      end
   endtask

   // Compare instance k against the model, then advance the model by the
   // effect of the current inputs at the coming edge when upd is set.
   task automatic model_cycle(input int k, input bit upd);
      logic [31:0] lq [$];
      int          sz;
      logic        e_rdy, e_ena, e_enq;
      logic [31:0] e_head;
      if (k == 0) lq = q0; else lq = q1;
      sz     = lq.size();
      e_rdy  = (k == 1) ? 1'b1 : (sz < DEPTH);
      e_ena  = (sz > 0) && rdy && !fl;
      e_head = (sz > 0) ? lq[0] : 32'h0;
      chk($sformatf("d%0d say_rdy", k), 64'(srdy[k]), 64'(e_rdy));
      chk($sformatf("d%0d heard_ena", k), 64'(hena[k]), 64'(e_ena));
      chk($sformatf("d%0d heard_meth", k), 64'(hmeth[k]), 64'(e_head[31:16]));
      chk($sformatf("d%0d heard_v", k), 64'(hv[k]), 64'(e_head[15:0]));
      chk($sformatf("d%0d occupancy", k), 64'(occ[k]), 64'(sz));
      chk($sformatf("d%0d drop_count", k), 64'(dcnt[k]), 64'(mdrop[k]));
      chk($sformatf("d%0d heard_seq", k), 64'(hseq[k]), 64'(mseq[k]));
      if (upd) begin
         e_enq = ena && e_rdy && !fl;
         if (fl) begin
            lq.delete();
         end else begin
            if (e_ena) begin
               void'(lq.pop_front());
               mseq[k]  = mseq[k] + 1'b1;
               deliv[k] = deliv[k] + 1;
            end
            if (e_enq) begin
               if (lq.size() == DEPTH) begin
                  void'(lq.pop_front());
                  if (mdrop[k] != '1) mdrop[k] = mdrop[k] + 1'b1;
               end
               lq.push_back({meth, v});
            end
         end
         if (k == 0) q0 = lq; else q1 = lq;
      end
   endtask

   task automatic step(input logic e, input logic [MW-1:0] m, input logic [DW-1:0] vv,
                       input logic r, input logic f);
      @(negedge CLK);
      ena  = e;
      meth = m;
      v    = vv;
      rdy  = r;
      fl   = f;
      #1;
      model_cycle(0, 1'b1);
      model_cycle(1, 1'b1);
      $display("step ena=%0d meth=%0h v=%0h rdy=%0d flush=%0d occ0=%0d occ1=%0d seq0=%0d drop1=%0d",
               e, m, vv, r, f, occ[0], occ[1], hseq[0], dcnt[1]);
   endtask

   task automatic idle(input logic r, input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, r, 1'b0);
   endtask

   // Assert reset between clock edges and check outputs before any edge.
   task automatic async_reset();
      @(negedge CLK);
      ena = 1'b1;
      rdy = 1'b1;
      fl  = 1'b0;
      #2 nRST = 1'b0;
      #1;
      model_clear();
      model_cycle(0, 1'b0);
      model_cycle(1, 1'b0);
      @(posedge CLK);
      #2;
      model_cycle(0, 1'b0);
      model_cycle(1, 1'b0);
      nRST = 1'b1;
      $display("async reset applied and released");
   endtask

   logic [SEQ_W-1:0] seq_hold;
   int               guard;

   initial begin
      model_clear();
      #12 nRST = 1'b1;
      idle(1'b0, 1);

      // Three requests held off, then drained back to back.
      step(1'b1, 16'd1, 16'hA, 1'b0, 1'b0);
      step(1'b1, 16'd2, 16'hB, 1'b0, 1'b0);
      step(1'b1, 16'd3, 16'hC, 1'b0, 1'b0);
      idle(1'b0, 1);
      chk("t1 occupancy", 64'(occ[0]), 64'd3);
      idle(1'b1, 3);
      idle(1'b1, 1);
      chk("t1 heard_seq", 64'(hseq[0]), 64'd3);
      chk("t1 meth empty", 64'(hmeth[0]), 64'd0);

      // Six requests into a stalled buffer: backpressure vs drop-oldest.
      for (int i = 1; i <= 6; i++) step(1'b1, MW'(i), DW'(16'h100 + i), 1'b0, 1'b0);
      idle(1'b0, 1);
      chk("t2 occ0", 64'(occ[0]), 64'd4);
      chk("t3 drop1", 64'(dcnt[1]), 64'd2);
      chk("t3 head1", 64'(hmeth[1]), 64'd3);
      idle(1'b1, 5);

      // Full buffer with a simultaneous request and delivery.
      for (int i = 0; i < 4; i++) step(1'b1, MW'(16'h20 + i), DW'(i), 1'b0, 1'b0);
      step(1'b1, 16'h99, 16'h99, 1'b1, 1'b0);
      idle(1'b0, 1);
      chk("t4 occ1", 64'(occ[1]), 64'd4);
      chk("t4 drop1", 64'(dcnt[1]), 64'd2);
      chk("t4 occ0", 64'(occ[0]), 64'd3);
      idle(1'b1, 5);

      // Flush with request and delivery both asserted.
      step(1'b1, 16'h31, 16'h1, 1'b0, 1'b0);
      step(1'b1, 16'h32, 16'h2, 1'b0, 1'b0);
      seq_hold = hseq[0];
      step(1'b1, 16'h33, 16'h3, 1'b1, 1'b1);
      idle(1'b0, 1);
      chk("t5 occ0", 64'(occ[0]), 64'd0);
      chk("t5 seq0", 64'(hseq[0]), 64'(seq_hold));

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), MW'($urandom), DW'($urandom),
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
      end

      // Asynchronous reset with three entries held.
      step(1'b0, '0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, MW'(16'h40 + i), DW'(i), 1'b0, 1'b0);
      async_reset();
      step(1'b1, 16'h55, 16'h66, 1'b1, 1'b0);
      step(1'b0, '0, '0, 1'b1, 1'b0);
      idle(1'b0, 1);
      chk("t6 seq0 after reset", 64'(hseq[0]), 64'd1);

      // Sequence counter wrap after 2^SEQ_W + 1 deliveries.
      async_reset();
      guard = 0;
      while (deliv[0] < (1 << SEQ_W) + 1 && guard < 3000) begin
         step(1'b1, MW'($urandom), DW'($urandom), 1'b1, 1'b0);
         guard++;
      end
      step(1'b0, '0, '0, 1'b0, 1'b0);
      chk("t6 wrap seq0", 64'(hseq[0]), 64'd1);
      chk("t6 wrap seq1", 64'(hseq[1]), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
